pcs_tx_oset_mc: RTL



---
 rtl/pcs_tx_oset_pkg.sv | 70 +++++++
 rtl/pcs_tx_oset_lane.sv | 218 +++++++++++++++++++++
 rtl/pcs_tx_oset_mc.sv | 50 +++++
 3 files changed

// File: rtl/pcs_tx_oset_pkg.sv
// pcs_tx_oset_pkg: shared types and constants for the multi-lane 1000BASE-X
// PCS transmit ordered-set block.
//   - tx_state_e : per-lane transmit FSM state encoding
//   - OSET_*     : tx_o_set codes driven to the code-group generator
//   - XMIT_*     : xmit encodings (3 is reserved and behaves like IDLE)
//   - TXD_*      : special TXD codes for carrier extend and LPI request
// Optional feature macro: PCS_TX_LPI_EN (adds XMIT_LPIDLE and /LI/ emission).
package pcs_tx_oset_pkg;

  typedef enum logic [3:0] {
    ST_TX_TEST_XMIT     = 4'd0,
    ST_CONFIGURATION    = 4'd1,
    ST_IDLE             = 4'd2,
    ST_XMIT_DATA        = 4'd3,
    ST_ALIGN_ERR_START  = 4'd4,
    ST_START_ERROR      = 4'd5,
    ST_TX_DATA_ERROR    = 4'd6,
    ST_START_OF_PACKET  = 4'd7,
    ST_TX_DATA          = 4'd8,
    ST_EOP_NOEXT        = 4'd9,
    ST_EOP_EXT          = 4'd10,
    ST_EXTEND_BY_1      = 4'd11,
    ST_CARRIER_EXTEND   = 4'd12,
    ST_EPD2_NOEXT       = 4'd13,
    ST_EPD3             = 4'd14,
    ST_XMIT_LPIDLE      = 4'd15
  } tx_state_e;

  localparam logic [2:0] OSET_C  = 3'd0;
  localparam logic [2:0] OSET_I  = 3'd1;
  localparam logic [2:0] OSET_S  = 3'd2;
  localparam logic [2:0] OSET_V  = 3'd3;
  localparam logic [2:0] OSET_T  = 3'd4;
  localparam logic [2:0] OSET_R  = 3'd5;
  localparam logic [2:0] OSET_D  = 3'd6;
  localparam logic [2:0] OSET_LI = 3'd7;

  localparam logic [1:0] XMIT_CONFIG = 2'd0;
  localparam logic [1:0] XMIT_IDLE   = 2'd1;
  localparam logic [1:0] XMIT_DATA   = 2'd2;

  localparam logic [7:0] TXD_EXTEND = 8'h0F;
  localparam logic [7:0] TXD_LPI    = 8'h01;

  // VOID: an error during a frame, or TX_ER outside a frame that is not a
  // legal carrier-extend request.
  function automatic logic is_void(input logic tx_en, input logic tx_er,
                                   input logic [7:0] txd);
    return (!tx_en && tx_er && (txd != TXD_EXTEND)) || (tx_en && tx_er);
  endfunction

  // Packet branch taken from the data states once an ordered set completes.
  function automatic tx_state_e pb_next(input logic tx_en, input logic tx_er);
    tx_state_e nxt;
    if (tx_en) begin
      nxt = ST_TX_DATA;
    end else if (tx_er) begin
      nxt = ST_EOP_EXT;
    end else begin
      nxt = ST_EOP_NOEXT;
    end
    return nxt;
  endfunction

  // States in which a VOID input is counted.
  function automatic logic void_sensitive(input tx_state_e st);
    return (st == ST_TX_DATA) || (st == ST_EOP_EXT) || (st == ST_CARRIER_EXTEND);
  endfunction

endpackage

// File: rtl/pcs_tx_oset_lane.sv
// pcs_tx_oset_lane: one lane of the transmit ordered-set FSM plus its
// saturating VOID-event counter. All outputs are registered.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   tx_en/tx_er/txd     GMII transmit inputs for this lane
//   xmit                xmit mode (0 CONFIG, 1 IDLE, 2 DATA, 3 as IDLE)
//   tx_even             code-group parity from the generator
//   tx_oset_ind         ordered-set-complete strobe
//   receiving           receive activity (for COL)
//   void_cnt_clr        synchronous counter clear (beats increment)
//   tx_o_set            selected ordered set
//   transmitting, col   status flags
//   void_cnt            saturating VOID count
// Optional feature macro: PCS_TX_LPI_EN.
module pcs_tx_oset_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_en,
  input  logic             tx_er,
  input  logic [7:0]       txd,
  input  logic [1:0]       xmit,
  input  logic             tx_even,
  input  logic             tx_oset_ind,
  input  logic             receiving,
  input  logic             void_cnt_clr,
  output logic [2:0]       tx_o_set,
  output logic             transmitting,
  output logic             col,
  output logic [CNT_W-1:0] void_cnt
);
  import pcs_tx_oset_pkg::*;

  tx_state_e        state_q, state_d;
  logic [2:0]       tx_o_set_q, tx_o_set_d;
  logic             transmitting_q, transmitting_d;
  logic             col_q, col_d;
  logic [CNT_W-1:0] void_cnt_q, void_cnt_d;
  logic [1:0]       xmit_hist_q, xmit_hist_d;
  logic             xmit_vld_q, xmit_vld_d;
  logic             void_s, lpi_s, xmit_chg_s;

  // Decode per-cycle input conditions and the xmit-change detector.
  always_comb begin
    void_s      = is_void(tx_en, tx_er, txd);
    lpi_s       = !tx_en && tx_er && (txd == TXD_LPI);
    // Until the history is loaded after reset it counts as equal to xmit.
    xmit_chg_s  = xmit_vld_q && (xmit != xmit_hist_q);
    xmit_hist_d = xmit;
    xmit_vld_d  = 1'b1;
  end

  // Next-state logic; the xmit-change rule overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TX_TEST_XMIT: begin
        if (xmit == XMIT_CONFIG) begin
          state_d = ST_CONFIGURATION;
        end else if ((xmit == XMIT_DATA) && !tx_en && !tx_er) begin
          state_d = ST_XMIT_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONFIGURATION: state_d = ST_CONFIGURATION;
      ST_IDLE: begin
        if (tx_oset_ind && (xmit == XMIT_DATA) && !tx_en && !tx_er) begin
          state_d = ST_XMIT_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XMIT_DATA: begin
        if (!tx_oset_ind) begin
          state_d = ST_XMIT_DATA;
        end else if (tx_en && tx_er) begin
          state_d = ST_ALIGN_ERR_START;
        end else if (tx_en) begin
          state_d = ST_START_OF_PACKET;
`ifdef PCS_TX_LPI_EN
        end else if (lpi_s) begin
          state_d = ST_XMIT_LPIDLE;
`endif
        end else begin
          state_d = ST_XMIT_DATA;
        end
      end
      ST_ALIGN_ERR_START: state_d = tx_oset_ind ? ST_START_ERROR : state_q;
      ST_START_ERROR:     state_d = tx_oset_ind ? ST_TX_DATA_ERROR : state_q;
      ST_TX_DATA_ERROR, ST_START_OF_PACKET, ST_TX_DATA: begin
        state_d = tx_oset_ind ? pb_next(tx_en, tx_er) : state_q;
      end
      ST_EOP_NOEXT, ST_EXTEND_BY_1: begin
        state_d = tx_oset_ind ? ST_EPD2_NOEXT : state_q;
      end
      ST_EOP_EXT: begin
        if (!tx_oset_ind) begin
          state_d = ST_EOP_EXT;
        end else if (tx_er) begin
          state_d = ST_CARRIER_EXTEND;
        end else begin
          state_d = ST_EXTEND_BY_1;
        end
      end
      ST_CARRIER_EXTEND: begin
        if (!tx_oset_ind || (!tx_en && tx_er)) begin
          state_d = ST_CARRIER_EXTEND;
        end else if (tx_en && tx_er) begin
          state_d = ST_START_ERROR;
        end else if (tx_en) begin
          state_d = ST_START_OF_PACKET;
        end else begin
          state_d = ST_EXTEND_BY_1;
        end
      end
      ST_EPD2_NOEXT: begin
        if (!tx_oset_ind) begin
          state_d = ST_EPD2_NOEXT;
        end else if (tx_even) begin
          state_d = ST_EPD3;
        end else begin
          state_d = ST_XMIT_DATA;
        end
      end
      ST_EPD3: state_d = tx_oset_ind ? ST_XMIT_DATA : state_q;
`ifdef PCS_TX_LPI_EN
      ST_XMIT_LPIDLE: state_d = (tx_oset_ind && !lpi_s) ? ST_XMIT_DATA : state_q;
`endif
      default: state_d = ST_TX_TEST_XMIT;
    endcase
    if (xmit_chg_s && tx_oset_ind && !tx_even) begin
      state_d = ST_TX_TEST_XMIT;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the next state and the inputs sampled at this edge.
  always_comb begin
    tx_o_set_d     = tx_o_set_q;
    transmitting_d = transmitting_q;
    case (state_d)
      ST_TX_TEST_XMIT:    transmitting_d = 1'b0;
      ST_CONFIGURATION:   tx_o_set_d = OSET_C;
      ST_IDLE, ST_XMIT_DATA, ST_ALIGN_ERR_START: tx_o_set_d = OSET_I;
      ST_START_ERROR, ST_START_OF_PACKET: begin
        tx_o_set_d     = OSET_S;
        transmitting_d = 1'b1;
      end
      ST_TX_DATA_ERROR:   tx_o_set_d = OSET_V;
      ST_TX_DATA:         tx_o_set_d = void_s ? OSET_V : OSET_D;
      ST_EOP_NOEXT, ST_EXTEND_BY_1: begin
        tx_o_set_d = (state_d == ST_EOP_NOEXT) ? OSET_T : OSET_R;
        // Carrier drops only on an odd code-group boundary.
        if (!tx_even) begin
          transmitting_d = 1'b0;
        end else begin
          transmitting_d = transmitting_q;
        end
      end
      ST_EOP_EXT:         tx_o_set_d = void_s ? OSET_V : OSET_T;
      ST_CARRIER_EXTEND:  tx_o_set_d = void_s ? OSET_V : OSET_R;
      ST_EPD2_NOEXT: begin
        tx_o_set_d     = OSET_R;
        transmitting_d = 1'b0;
      end
      ST_EPD3:            tx_o_set_d = OSET_R;
`ifdef PCS_TX_LPI_EN
      ST_XMIT_LPIDLE:     tx_o_set_d = OSET_LI;
`endif
      default: begin
        tx_o_set_d     = OSET_I;
        transmitting_d = 1'b0;
      end
    endcase
    col_d = transmitting_d && receiving;
  end

  // VOID counter: clear beats increment, increment saturates at all-ones.
  always_comb begin
    if (void_cnt_clr) begin
      void_cnt_d = {CNT_W{1'b0}};
    end else if (void_sensitive(state_q) && void_s && (void_cnt_q != {CNT_W{1'b1}})) begin
      void_cnt_d = void_cnt_q + CNT_W'(1);
    end else begin
      void_cnt_d = void_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_TX_TEST_XMIT;
      tx_o_set_q     <= OSET_I;
      transmitting_q <= 1'b0;
      col_q          <= 1'b0;
      void_cnt_q     <= {CNT_W{1'b0}};
      xmit_hist_q    <= 2'd0;
      xmit_vld_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_o_set_q     <= tx_o_set_d;
      transmitting_q <= transmitting_d;
      col_q          <= col_d;
      void_cnt_q     <= void_cnt_d;
      xmit_hist_q    <= xmit_hist_d;
      xmit_vld_q     <= xmit_vld_d;
    end
  end

  assign tx_o_set     = tx_o_set_q;
  assign transmitting = transmitting_q;
  assign col          = col_q;
  assign void_cnt     = void_cnt_q;

endmodule

// File: rtl/pcs_tx_oset_mc.sv
// pcs_tx_oset_mc: multi-lane 1000BASE-X PCS transmit ordered-set selector.
// NUM_CH independent lanes share one clock and asynchronous active-low reset.
// Per-lane buses are packed with lane i in the i-th slice:
//   TX_EN, TX_ER, tx_even, TX_OSET_indicate, receiving, void_cnt_clr [i]
//   TXD [8i+7:8i], xmit [2i+1:2i], tx_o_set [3i+2:3i]
//   transmitting, COL [i], void_cnt [CNT_W*i +: CNT_W]
// Optional feature macro: PCS_TX_LPI_EN (EEE low-power idle).
module pcs_tx_oset_mc #(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       TX_EN,
  input  logic [NUM_CH-1:0]       TX_ER,
  input  logic [8*NUM_CH-1:0]     TXD,
  input  logic [2*NUM_CH-1:0]     xmit,
  input  logic [NUM_CH-1:0]       tx_even,
  input  logic [NUM_CH-1:0]       TX_OSET_indicate,
  input  logic [NUM_CH-1:0]       receiving,
  input  logic [NUM_CH-1:0]       void_cnt_clr,
  output logic [3*NUM_CH-1:0]     tx_o_set,
  output logic [NUM_CH-1:0]       transmitting,
  output logic [NUM_CH-1:0]       COL,
  output logic [CNT_W*NUM_CH-1:0] void_cnt
);
  import pcs_tx_oset_pkg::*;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    pcs_tx_oset_lane #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .tx_en        (TX_EN[i]),
      .tx_er        (TX_ER[i]),
      .txd          (TXD[8*i +: 8]),
      .xmit         (xmit[2*i +: 2]),
      .tx_even      (tx_even[i]),
      .tx_oset_ind  (TX_OSET_indicate[i]),
      .receiving    (receiving[i]),
      .void_cnt_clr (void_cnt_clr[i]),
      .tx_o_set     (tx_o_set[3*i +: 3]),
      .transmitting (transmitting[i]),
      .col          (COL[i]),
      .void_cnt     (void_cnt[CNT_W*i +: CNT_W])
    );
  end

endmodule
